// File: rtl/kros_pkg.sv
// Shared definitions for the KROS LED sequencer: mode encodings, a ceiling-log2
// helper and the per-mode next-pattern / start-pattern functions.
package kros_pkg;

  typedef enum logic [1:0] {
    MODE_SCAN = 2'd0,
    MODE_ROT  = 2'd1,
    MODE_BAR  = 2'd2,
    MODE_CNT  = 2'd3
  } mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic logic [31:0] led_mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // Patterns are carried in 32 bits; the caller truncates to its LED count.
  function automatic logic [31:0] next_pattern(input mode_e mode, input logic [31:0] cur,
                                               input logic up, input int n);
    logic [31:0] m;
    m = led_mask(n);
    case (mode)
      MODE_SCAN: next_pattern = up ? ((cur << 1) & m) : (cur >> 1);
      MODE_ROT:  next_pattern = ((cur << 1) | (cur >> (n - 1))) & m;
      MODE_BAR:  next_pattern = (cur == m) ? 32'd0 : (((cur << 1) | 32'd1) & m);
      default:   next_pattern = (cur + 32'd1) & m;
    endcase
  endfunction

  function automatic logic [31:0] start_pattern(input mode_e mode);
    return (mode == MODE_CNT) ? 32'd0 : 32'd1;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stability counter
// and a one-cycle pulse on each accepted press (filtered 1 -> 0).
module pb_debounce
  import kros_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic press
);

  localparam int CNTW = (clog2(DB_CYCLES + 1) < 1) ? 1 : clog2(DB_CYCLES + 1);

  logic            sync_a;
  logic            sync_b;
  logic            state;
  logic [CNTW-1:0] count;

  // Any sample agreeing with the filtered state restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      state  <= 1'b1;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= pb;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == state) begin
        count <= '0;
      end else if (count == CNTW'(DB_CYCLES - 1)) begin
        count <= '0;
        state <= sync_b;
        press <= ~sync_b;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kros_led_sequencer.sv
// LED pattern engine: debounced buttons step a rate level and a mode, a
// prescaler generates the advance tick and the LEDR register follows the mode.
module kros_led_sequencer
  import kros_pkg::*;
#(
  parameter int N_LEDS    = 10,
  parameter int SEQ_COUNT = 4,
  parameter int LEVELS    = 8,
  parameter int FREQ_INIT = 7,
  parameter int BASE_DIV  = 64,
  parameter int DB_CYCLES = 16,
  localparam int LW       = clog2(LEVELS)
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              pb_freq_up,
  input  logic              pb_freq_dn,
  input  logic              pb_seq_up,
  input  logic              pb_seq_dn,
  output logic [N_LEDS-1:0] LEDR,
  output logic [LW-1:0]     freq_level,
  output logic [1:0]        seq_sel,
  output logic              tick
);

  localparam int CW = clog2(BASE_DIV) + LEVELS;

  logic [3:0]        raw;
  logic [3:0]        press;
  logic              freq_inc;
  logic              freq_dec;
  logic              seq_chg;
  logic [1:0]        seq_next;
  logic [CW-1:0]     period;
  logic [CW-1:0]     count;
  logic              scan_up;
  logic [N_LEDS-1:0] pat_next;

  assign raw = {pb_seq_dn, pb_seq_up, pb_freq_dn, pb_freq_up};

  for (genvar i = 0; i < 4; i++) begin : g_db
    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (CLK_50),
      .rst_n(reset),
      .pb   (raw[i]),
      .press(press[i])
    );
  end

  // Opposing presses in the same cycle cancel; saturated steps are not changes.
  assign freq_inc = press[0] & ~press[1] & (freq_level != LW'(LEVELS - 1));
  assign freq_dec = press[1] & ~press[0] & (freq_level != '0);

  always_comb begin
    seq_next = seq_sel;
    if (press[2] && !press[3])
      seq_next = (seq_sel == 2'(SEQ_COUNT - 1)) ? 2'd0 : seq_sel + 2'd1;
    else if (press[3] && !press[2])
      seq_next = (seq_sel == 2'd0) ? 2'(SEQ_COUNT - 1) : seq_sel - 2'd1;
  end

  assign seq_chg  = (seq_next != seq_sel);
  assign period   = CW'(BASE_DIV) << (LW'(LEVELS - 1) - freq_level);
  assign pat_next = N_LEDS'(next_pattern(mode_e'(seq_sel), 32'(LEDR), scan_up, N_LEDS));

  // A control change restarts the period and suppresses the tick for that cycle.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      freq_level <= LW'(FREQ_INIT);
      seq_sel    <= 2'd0;
      LEDR       <= N_LEDS'(1);
      tick       <= 1'b0;
      count      <= '0;
      scan_up    <= 1'b1;
    end else begin
      tick    <= 1'b0;
      seq_sel <= seq_next;
      if (freq_inc)
        freq_level <= freq_level + 1'b1;
      else if (freq_dec)
        freq_level <= freq_level - 1'b1;

      if (freq_inc || freq_dec || seq_chg) begin
        count <= '0;
        if (seq_chg) begin
          LEDR    <= N_LEDS'(start_pattern(mode_e'(seq_next)));
          scan_up <= 1'b1;
        end
      end else if (count == period - 1'b1) begin
        count <= '0;
        tick  <= 1'b1;
        LEDR  <= pat_next;
        if (seq_sel == MODE_SCAN) begin
          if (scan_up && pat_next[N_LEDS-1])
            scan_up <= 1'b0;
          else if (!scan_up && pat_next[0])
            scan_up <= 1'b1;
        end
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kros_led_sequencer.sv
// Directed self-checking bench for kros_led_sequencer at default parameters:
// scanner/rotate/bar/count patterns, rate saturation, debounce and async reset.
module tb_kros_led_sequencer;

  logic       CLK_50 = 1'b0;
  logic       reset;
  logic [3:0] pb;
  logic [9:0] LEDR;
  logic [2:0] freq_level;
  logic [1:0] seq_sel;
  logic       tick;

  int errors = 0;
  int checks = 0;
  int n;

  logic [9:0] scan_exp [0:10] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                                  10'h080, 10'h100, 10'h200, 10'h100, 10'h080};
  logic [9:0] rot_exp  [0:8]  = '{10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                                  10'h080, 10'h100, 10'h200, 10'h001};
  logic [9:0] bar_exp  [0:9]  = '{10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F,
                                  10'h0FF, 10'h1FF, 10'h3FF, 10'h000, 10'h001};

  always #5 CLK_50 = ~CLK_50;

  kros_led_sequencer dut (
    .CLK_50    (CLK_50),
    .reset     (reset),
    .pb_freq_up(pb[0]),
    .pb_freq_dn(pb[1]),
    .pb_seq_up (pb[2]),
    .pb_seq_dn (pb[3]),
    .LEDR      (LEDR),
    .freq_level(freq_level),
    .seq_sel   (seq_sel),
    .tick      (tick)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Counts falling edges until tick is seen; an expired bound is a failed check.
  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK_50);
      cycles++;
    end while (tick !== 1'b1 && cycles < 1000);
    checkOutput("tick_seen", 32'(tick), 32'd1);
  endtask

  // Drives a button low and waits until the control register has taken the press.
  task automatic applyStimulus(input int b);
    pb[b] = 1'b0;
    repeat (19) @(negedge CLK_50);
  endtask

  initial begin
    reset = 1'b0;
    pb    = 4'hF;
    repeat (5) @(negedge CLK_50);
    checkOutput("rst_ledr", 32'(LEDR), 32'h001);
    checkOutput("rst_freq", 32'(freq_level), 32'd7);
    checkOutput("rst_seq", 32'(seq_sel), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);

    $display("[TB] scanner mode");
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      waitTick(n);
      checkOutput("scan_period", 32'(n), 32'd64);
      checkOutput("scan_ledr", 32'(LEDR), 32'(scan_exp[i]));
    end
    @(negedge CLK_50);
    checkOutput("tick_one_cycle", 32'(tick), 32'd0);

    $display("[TB] rotate mode");
    applyStimulus(2);
    checkOutput("seq_up_1", 32'(seq_sel), 32'd1);
    checkOutput("rot_reload", 32'(LEDR), 32'h001);
    checkOutput("rot_no_tick", 32'(tick), 32'd0);
    repeat (31) @(negedge CLK_50);
    pb = 4'hF;
    waitTick(n);
    checkOutput("rot_first_tick", 32'(n), 32'd33);
    checkOutput("rot_ledr0", 32'(LEDR), 32'h002);
    for (int i = 0; i < 9; i++) begin
      waitTick(n);
      checkOutput("rot_period", 32'(n), 32'd64);
      checkOutput("rot_ledr", 32'(LEDR), 32'(rot_exp[i]));
    end

    $display("[TB] bar mode");
    applyStimulus(2);
    checkOutput("seq_up_2", 32'(seq_sel), 32'd2);
    checkOutput("bar_reload", 32'(LEDR), 32'h001);
    repeat (31) @(negedge CLK_50);
    pb = 4'hF;
    waitTick(n);
    checkOutput("bar_first_tick", 32'(n), 32'd33);
    checkOutput("bar_ledr0", 32'(LEDR), 32'h003);
    for (int i = 0; i < 10; i++) begin
      waitTick(n);
      checkOutput("bar_ledr", 32'(LEDR), 32'(bar_exp[i]));
    end

    $display("[TB] rate down and saturation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("freq_dn", 32'(freq_level), 32'(6 - i));
      pb = 4'hF;
      repeat (25) @(negedge CLK_50);
    end
    waitTick(n);
    checkOutput("slow_first_tick", 32'(n), 32'd487);
    waitTick(n);
    checkOutput("slow_period", 32'(n), 32'd512);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0);
      checkOutput("freq_up", 32'((i < 2) ? 5 + i : 7), 32'(freq_level));
      pb = 4'hF;
      repeat (25) @(negedge CLK_50);
    end

    $display("[TB] bounce and wrap to count mode");
    applyStimulus(3);
    checkOutput("seq_dn_1", 32'(seq_sel), 32'd1);
    pb = 4'hF;
    repeat (25) @(negedge CLK_50);
    applyStimulus(3);
    checkOutput("seq_dn_0", 32'(seq_sel), 32'd0);
    checkOutput("scan_reload", 32'(LEDR), 32'h001);
    pb = 4'hF;
    repeat (25) @(negedge CLK_50);
    repeat (4) begin
      pb[3] = 1'b0;
      repeat (10) @(negedge CLK_50);
      pb[3] = 1'b1;
      repeat (5) @(negedge CLK_50);
    end
    pb[3] = 1'b0;
    repeat (18) @(negedge CLK_50);
    checkOutput("bounce_ignored", 32'(seq_sel), 32'd0);
    @(negedge CLK_50);
    checkOutput("seq_wrap", 32'(seq_sel), 32'd3);
    checkOutput("cnt_reload", 32'(LEDR), 32'h000);
    repeat (31) @(negedge CLK_50);
    pb = 4'hF;
    repeat (30) @(negedge CLK_50);
    checkOutput("single_press", 32'(seq_sel), 32'd3);
    waitTick(n);
    checkOutput("cnt_first_tick", 32'(n), 32'd3);
    checkOutput("cnt_ledr1", 32'(LEDR), 32'h001);
    waitTick(n);
    checkOutput("cnt_ledr2", 32'(LEDR), 32'h002);

    $display("[TB] simultaneous rate buttons");
    waitTick(n);
    checkOutput("cnt_ledr3", 32'(LEDR), 32'h003);
    pb[0] = 1'b0;
    pb[1] = 1'b0;
    waitTick(n);
    checkOutput("both_no_clear", 32'(n), 32'd64);
    checkOutput("both_freq", 32'(freq_level), 32'd7);
    checkOutput("cnt_ledr4", 32'(LEDR), 32'h004);
    pb = 4'hF;

    $display("[TB] async reset mid-period");
    for (int i = 0; i < 300 && LEDR !== 10'h0A5; i++) waitTick(n);
    checkOutput("reach_0A5", 32'(LEDR), 32'h0A5);
    repeat (20) @(negedge CLK_50);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_ledr", 32'(LEDR), 32'h001);
    checkOutput("async_seq", 32'(seq_sel), 32'd0);
    checkOutput("async_freq", 32'(freq_level), 32'd7);
    checkOutput("async_tick", 32'(tick), 32'd0);
    repeat (3) @(negedge CLK_50);
    reset = 1'b1;
    waitTick(n);
    checkOutput("post_rst_tick", 32'(n), 32'd64);
    checkOutput("post_rst_ledr", 32'(LEDR), 32'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
